regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU/execute path (port 0) and the load/multi-cycle unit (port 1).
- Also keeps a pending-write scoreboard so decode can stall on registers whose load has not yet written back.
- Sits between execute/memory stages and the register file; drives its WE3/AD3/WD3 inputs from registers.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
- STARVE_MAX, 3, consecutive lost arbitrations after which port 0 is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb0_valid  in  1  port 0 (ALU) write request.
- wb0_rd  in  5  port 0 destination register.
- wb0_data  in  XLEN  port 0 write data.
- wb0_ready  out  1  port 0 accepted this cycle.
- wb1_valid  in  1  port 1 (load) write request.
- wb1_rd  in  5  port 1 destination register.
- wb1_data  in  XLEN  port 1 write data.
- wb1_ready  out  1  port 1 accepted this cycle.
- iss_valid  in  1  a load is issuing; mark iss_rd pending.
- iss_rd  in  5  destination of the issuing load.
- q_rs1  in  5  decode source 1 query.
- q_rs2  in  5  decode source 2 query.
- hazard  out  1  q_rs1 or q_rs2 is pending (combinational).
- we3  out  1  register file write enable (registered).
- ad3  out  5  register file write address (registered).
- wd3  out  XLEN  register file write data (registered).
- pend_cnt  out  6  number of pending registers (registered popcount).
- sb_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - we3=0, ad3=0, wd3=0.
  - Scoreboard cleared, pend_cnt=0, sb_err=0, starvation counter=0.
- Arbitration (combinational ready, one grant per cycle):
  - Only one valid: that port gets ready=1.
  - Both valid: port 1 wins, unless the starvation counter equals STARVE_MAX; then port 0 wins.
  - Starvation counter increments when port 0 is valid and loses.
  - It clears when port 0 wins or is not valid. It saturates at STARVE_MAX.
  - A source holds valid/rd/data stable until ready; transfer occurs when valid && ready.
- Write stage:
  - On transfer in cycle N, we3/ad3/wd3 carry the winner in cycle N+1. Latency is exactly 1 cycle.
  - Otherwise we3=0 in cycle N+1; ad3/wd3 hold their last values.
  - rd=0 transfers are accepted (ready=1) but produce we3=0. x0 is never written.
- Scoreboard (NREG-bit vector, bit 0 hard-wired 0):
  - iss_valid with iss_rd!=0 sets bit iss_rd at the next edge.
  - A port 1 transfer clears bit wb1_rd at the next edge.
  - Same rd set and cleared in the same cycle: set wins (newer load). pend_cnt is unchanged.
  - iss_valid to an already-pending rd sets sb_err.
  - A port 1 transfer to a non-pending rd (rd!=0) sets sb_err.
  - sb_err clears only on reset.
  - Port 0 never touches the scoreboard.
- hazard = pend[q_rs1] | pend[q_rs2]. q=0 never hazards. Reflects the registered scoreboard only; no bypass of the same-cycle clear.
- pend_cnt equals popcount of the scoreboard, updated with it.
- Reset asserted mid-transfer: in-flight write dropped (we3 forced 0 immediately); scoreboard lost.

Test Plan:
- Reset then idle:
  - rst_n low, release.
  - Expect we3=0, pend_cnt=0, sb_err=0, hazard=0 for q_rs1=5, q_rs2=6.
- Single ALU write:
  - wb0_valid=1, rd=7, data=0xDEADBEEF in cycle N.
  - Expect wb0_ready=1 in N, and we3=1, ad3=7, wd3=0xDEADBEEF in N+1 only.
- Priority and starvation:
  - Both ports valid continuously with distinct rd, port 1 rd=3.
  - Expect port 1 granted 3 cycles, port 0 on the 4th, then pattern repeats. No cycle with both ready.
- Load scoreboard lifecycle:
  - iss_valid rd=10; next cycle q_rs1=10 gives hazard=1, pend_cnt=1.
  - wb1 rd=10 transfers; one cycle later hazard=0, pend_cnt=0, and we3 writes reg 10.
- x0 and errors:
  - wb0 rd=0 gives ready=1, we3 stays 0.
  - iss_valid rd=0 leaves pend_cnt=0.
  - Double issue rd=4 sets sb_err=1, which persists until reset.
- Simultaneous set/clear and mid-op reset:
  - wb1 rd=12 transfers while iss_valid rd=12 in the same cycle; expect bit 12 still pending, pend_cnt unchanged.
  - Assert rst_n during a transfer; expect we3=0 immediately and pend_cnt=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_wb_arbiter: shares the register-file write port between the   |
// | ALU and load writeback paths and tracks pending load destinations.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb0_valid,
  input  logic [4:0]      wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [4:0]      wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            hazard,
  output logic            we3,
  output logic [4:0]      ad3,
  output logic [XLEN-1:0] wd3,
  output logic [5:0]      pend_cnt,
  output logic            sb_err
);

  localparam int              c_SW        = $clog2(STARVE_MAX + 1);
  localparam logic [c_SW-1:0] c_STARVE_LIM = c_SW'(STARVE_MAX);
  localparam logic [NREG-1:0] c_X0_MASK   = {{(NREG-1){1'b1}}, 1'b0};

  logic [c_SW-1:0] r_starve;
  logic [NREG-1:0] r_pend;
  logic            r_we3;
  logic [4:0]      r_ad3;
  logic [XLEN-1:0] r_wd3;
  logic [5:0]      r_pend_cnt;
  logic            r_sb_err;

  logic            w_force0;
  logic            w_xfer0;
  logic            w_xfer1;
  logic [4:0]      w_wr_rd;
  logic [XLEN-1:0] w_wr_data;
  logic            w_wr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_pend_nxt;
  logic [5:0]      w_cnt;
  logic            w_err;

  // Port 1 normally wins; a starved port 0 is granted once the limit is hit.
  assign w_force0  = (r_starve == c_STARVE_LIM);
  assign wb0_ready = wb0_valid & (~wb1_valid | w_force0);
  assign wb1_ready = wb1_valid & ~(wb0_valid & w_force0);
  assign w_xfer0   = wb0_valid & wb0_ready;
  assign w_xfer1   = wb1_valid & wb1_ready;

  assign w_wr_rd   = w_xfer1 ? wb1_rd   : wb0_rd;
  assign w_wr_data = w_xfer1 ? wb1_data : wb0_data;
  assign w_wr      = (w_xfer0 | w_xfer1) & (w_wr_rd != 5'd0);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid && iss_rd != 5'd0) w_set[iss_rd] = 1'b1;
    if (w_xfer1) w_clr[wb1_rd] = 1'b1;
  end

  // Set after clear so a re-issue in the retiring cycle keeps the bit pending.
  assign w_pend_nxt = ((r_pend & ~w_clr) | w_set) & c_X0_MASK;

  assign w_err = (iss_valid && iss_rd != 5'd0 && r_pend[iss_rd]) ||
                 (w_xfer1 && wb1_rd != 5'd0 && !r_pend[wb1_rd]);

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NREG; i++) w_cnt = w_cnt + 6'(w_pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve   <= '0;
      r_pend     <= '0;
      r_we3      <= 1'b0;
      r_ad3      <= '0;
      r_wd3      <= '0;
      r_pend_cnt <= '0;
      r_sb_err   <= 1'b0;
    end else begin
      if (wb0_valid && !wb0_ready) begin
        if (r_starve != c_STARVE_LIM) r_starve <= r_starve + c_SW'(1);
      end else begin
        r_starve <= '0;
      end
      r_we3 <= w_wr;
      if (w_wr) begin
        r_ad3 <= w_wr_rd;
        r_wd3 <= w_wr_data;
      end
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt;
      r_sb_err   <= r_sb_err | w_err;
    end
  end

  assign hazard   = r_pend[q_rs1] | r_pend[q_rs2];
  assign we3      = r_we3;
  assign ad3      = r_ad3;
  assign wd3      = r_wd3;
  assign pend_cnt = r_pend_cnt;
  assign sb_err   = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter: directed self-checking bench for the writeback  |
// | arbiter and pending-load scoreboard.                                   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb0_valid;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        hazard;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic [5:0]  pend_cnt;
  logic        sb_err;

  int n_chk = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .hazard    (hazard),
    .we3       (we3),
    .ad3       (ad3),
    .wd3       (wd3),
    .pend_cnt  (pend_cnt),
    .sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    iss_valid = 1'b0; iss_rd = '0; q_rs1 = 5'd5; q_rs2 = 5'd6;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_we3", we3, 0);
    check("rst_ad3", ad3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_pend_cnt", pend_cnt, 0);
    check("rst_sb_err", sb_err, 0);
    check("rst_hazard", hazard, 0);

    // Single ALU write: visible exactly one cycle after the transfer.
    @(negedge clk);
    wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'hDEADBEEF;
    #1;
    check("alu_ready0", wb0_ready, 1);
    check("alu_ready1", wb1_ready, 0);
    @(posedge clk); #1;
    check("alu_we3", we3, 1);
    check("alu_ad3", ad3, 7);
    check("alu_wd3", wd3, 32'hDEADBEEF);
    @(negedge clk);
    wb0_valid = 1'b0;
    @(posedge clk); #1;
    check("alu_we3_off", we3, 0);
    check("alu_ad3_hold", ad3, 7);

    // Both ports continuously valid: port 1 x3, then port 0, repeating.
    @(negedge clk);
    wb0_valid = 1'b1; wb0_rd = 5'd8; wb0_data = 32'h0000_0008;
    wb1_valid = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h0000_0003;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("starve_r0_%0d", i), wb0_ready, (i % 4 == 3) ? 1 : 0);
      check($sformatf("starve_r1_%0d", i), wb1_ready, (i % 4 == 3) ? 0 : 1);
      check($sformatf("starve_both_%0d", i), wb0_ready & wb1_ready, 0);
      @(posedge clk); #1;
      check($sformatf("starve_ad3_%0d", i), ad3, (i % 4 == 3) ? 8 : 3);
      @(negedge clk);
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    #1;
    // Load writebacks to a never-issued register are an error.
    check("nonpend_sb_err", sb_err, 1);
    rst_n = 1'b0;
    #1;
    check("rst_clears_err", sb_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load scoreboard lifecycle on x10.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd10; q_rs1 = 5'd10; q_rs2 = 5'd0;
    #1;
    check("ld_haz_before", hazard, 0);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    check("ld_hazard", hazard, 1);
    check("ld_pend_cnt", pend_cnt, 1);
    @(negedge clk);
    wb1_valid = 1'b1; wb1_rd = 5'd10; wb1_data = 32'hCAFE0010;
    #1;
    check("ld_ready1", wb1_ready, 1);
    check("ld_haz_nobypass", hazard, 1);
    @(posedge clk); #1;
    check("ld_we3", we3, 1);
    check("ld_ad3", ad3, 10);
    check("ld_wd3", wd3, 32'hCAFE0010);
    check("ld_pend_clr", pend_cnt, 0);
    check("ld_haz_clr", hazard, 0);
    @(negedge clk);
    wb1_valid = 1'b0;
    check("ld_sb_err", sb_err, 0);

    // x0 handling and double-issue error.
    @(negedge clk);
    wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 32'h55;
    #1;
    check("x0_ready", wb0_ready, 1);
    @(posedge clk); #1;
    check("x0_we3", we3, 0);
    @(negedge clk);
    wb0_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd0; q_rs1 = 5'd0;
    @(posedge clk); #1;
    check("x0_iss_cnt", pend_cnt, 0);
    check("x0_hazard", hazard, 0);
    @(negedge clk);
    iss_rd = 5'd4;
    @(posedge clk); #1;
    check("iss4_cnt", pend_cnt, 1);
    check("iss4_err0", sb_err, 0);
    @(posedge clk); #1;
    check("dbl_iss_err", sb_err, 1);
    check("dbl_iss_cnt", pend_cnt, 1);
    @(negedge clk);
    iss_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", sb_err, 1);

    // Simultaneous set and clear on x12.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd12;
    @(negedge clk);
    wb1_valid = 1'b1; wb1_rd = 5'd12; wb1_data = 32'h1212_1212;
    q_rs1 = 5'd12;
    #1;
    check("sc_cnt_before", pend_cnt, 2);
    check("sc_ready1", wb1_ready, 1);
    @(posedge clk); #1;
    check("sc_cnt_after", pend_cnt, 2);
    check("sc_hazard", hazard, 1);
    check("sc_we3", we3, 1);
    check("sc_ad3", ad3, 12);
    @(negedge clk);
    iss_valid = 1'b0; wb1_valid = 1'b0;

    // Reset while a write is in flight.
    @(negedge clk);
    wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h0909_0909;
    @(posedge clk); #1;
    check("mid_we3_pre", we3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_we3_rst", we3, 0);
    check("mid_cnt_rst", pend_cnt, 0);
    check("mid_haz_rst", hazard, 0);
    wb0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_we3", we3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
